// File: rtl/sdf_pkg.sv
// Shared helpers for the SDF FFT stage: width helpers, Q-format constants,
// rounding and saturation arithmetic on a common 64-bit signed carrier.
package sdf_pkg;

    localparam real PI = 3.14159265358979323846;

    function automatic int sdf_clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Value of 1.0 in the Q2.(TW_W-2) twiddle format
    function automatic int tw_one(input int tw_w);
        return 1 << (tw_w - 2);
    endfunction

    function automatic int round_real(input real x);
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int sh);
        return (x + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic is_sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

// File: rtl/sdf_twiddle_lut.sv
// Constant twiddle ROM for one SDF stage: entry k holds exp(-j*pi*k/D),
// rounded to nearest in Q2.(TW_W-2); combinational read.
module sdf_twiddle_lut import sdf_pkg::*; #(
    parameter int FFT_N    = 1024,
    parameter int STAGE_NO = 1,
    parameter int TW_W     = 16,
    parameter int KW       = sdf_clog2(FFT_N >> STAGE_NO)
) (
    input  logic [KW-1:0]          k,
    output logic signed [TW_W-1:0] w_re,
    output logic signed [TW_W-1:0] w_im
);

    localparam int D = FFT_N >> STAGE_NO;

    logic signed [TW_W-1:0] rom_re [D];
    logic signed [TW_W-1:0] rom_im [D];

    for (genvar i = 0; i < D; i++) begin : g_rom
        localparam real ANG = PI * i / D;
        assign rom_re[i] = TW_W'(round_real(real'(tw_one(TW_W)) * $cos(ANG)));
        assign rom_im[i] = TW_W'(-round_real(real'(tw_one(TW_W)) * $sin(ANG)));
    end

    assign w_re = rom_re[k];
    assign w_im = rom_im[k];

endmodule

// File: rtl/sdf_stage_gen.sv
// Radix-2 single-path delay-feedback DIF FFT stage with internal frame
// sequencing, per-frame scaling and saturating arithmetic with a sticky flag.
module sdf_stage_gen import sdf_pkg::*; #(
    parameter int FFT_N    = 1024,
    parameter int STAGE_NO = 1,
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     scale_en,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     ovf
);

    localparam int D     = FFT_N >> STAGE_NO;
    localparam int CNT_W = sdf_clog2(2 * D);
    localparam int KW    = (D > 1) ? CNT_W - 1 : 1;
    localparam int SW    = DATA_W + 1;

    logic [CNT_W-1:0]        cnt;
    logic                    primed;
    logic                    scale_q;
    logic [2*DATA_W-1:0]     dly [D];

    logic                    fill;
    logic signed [DATA_W-1:0] a_re, a_im;
    logic signed [SW-1:0]    sum_re, sum_im, dif_re, dif_im;
    logic signed [DATA_W-1:0] s_re, s_im, d_re, d_im, t_re, t_im;
    logic                    bf_ovf, mul_ovf, sat_hit;

    // D is a power of two, so the top counter bit marks the butterfly phase
    assign fill = ~cnt[CNT_W-1];
    assign a_re = dly[D-1][2*DATA_W-1 -: DATA_W];
    assign a_im = dly[D-1][DATA_W-1:0];

    assign sum_re = SW'(a_re) + SW'(in_re);
    assign sum_im = SW'(a_im) + SW'(in_im);
    assign dif_re = SW'(a_re) - SW'(in_re);
    assign dif_im = SW'(a_im) - SW'(in_im);

    always_comb begin
        bf_ovf = 1'b0;
        if (scale_q) begin
            s_re = DATA_W'(sum_re >>> 1);
            s_im = DATA_W'(sum_im >>> 1);
            d_re = DATA_W'(dif_re >>> 1);
            d_im = DATA_W'(dif_im >>> 1);
        end else begin
            s_re = DATA_W'(sat_w(64'(sum_re), DATA_W));
            s_im = DATA_W'(sat_w(64'(sum_im), DATA_W));
            d_re = DATA_W'(sat_w(64'(dif_re), DATA_W));
            d_im = DATA_W'(sat_w(64'(dif_im), DATA_W));
            bf_ovf = is_sat(64'(sum_re), DATA_W) | is_sat(64'(sum_im), DATA_W)
                   | is_sat(64'(dif_re), DATA_W) | is_sat(64'(dif_im), DATA_W);
        end
    end

    if (D > 1) begin : g_tw
        logic signed [TW_W-1:0] w_re, w_im;
        logic signed [63:0]     p_re, p_im;

        sdf_twiddle_lut #(
            .FFT_N    (FFT_N),
            .STAGE_NO (STAGE_NO),
            .TW_W     (TW_W),
            .KW       (KW)
        ) u_lut (
            .k    (cnt[KW-1:0]),
            .w_re (w_re),
            .w_im (w_im)
        );

        assign p_re = round_shift(64'(d_re) * 64'(w_re) - 64'(d_im) * 64'(w_im), TW_W - 2);
        assign p_im = round_shift(64'(d_re) * 64'(w_im) + 64'(d_im) * 64'(w_re), TW_W - 2);
        assign t_re = DATA_W'(sat_w(p_re, DATA_W));
        assign t_im = DATA_W'(sat_w(p_im, DATA_W));
        assign mul_ovf = is_sat(p_re, DATA_W) | is_sat(p_im, DATA_W);
    end else begin : g_pass
        assign t_re    = d_re;
        assign t_im    = d_im;
        assign mul_ovf = 1'b0;
    end

    assign sat_hit = in_valid & ~fill & (bf_ovf | mul_ovf);

    // Control, output register and sticky flag; saturation wins over clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            scale_q   <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid & primed;
            if (sat_hit)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
            if (in_valid) begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(D - 1))
                    primed <= 1'b1;
                if (cnt == '0)
                    scale_q <= scale_en;
                if (primed) begin
                    out_re <= fill ? a_re : s_re;
                    out_im <= fill ? a_im : s_im;
                end
            end
        end
    end

    // Delay line holds raw inputs during fill and twiddled differences after
    always_ff @(posedge clk) begin
        if (in_valid) begin
            dly[0] <= fill ? {in_re, in_im} : {t_re, t_im};
            for (int i = D - 1; i > 0; i--)
                dly[i] <= dly[i-1];
        end
    end

endmodule

// File: tb/tb_sdf_stage_gen.sv
// Directed bench for an 8-point first stage (D = 4) with hand-computed
// frame results, scaling/saturation, valid gaps and mid-frame reset.
module tb_sdf_stage_gen;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic               scale_en = 1'b0;
    logic               ovf_clr = 1'b0;
    logic               out_valid;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               ovf;

    int assertCount = 0;
    int failCount   = 0;
    int validErrors = 0;
    int accCount    = 0;
    logic expValid  = 1'b0;

    logic signed [15:0] gotRe [$];
    logic signed [15:0] gotIm [$];
    int xr [12];
    int xi [12];
    int er [8];
    int ei [8];

    sdf_stage_gen #(
        .FFT_N    (8),
        .STAGE_NO (1),
        .DATA_W   (16),
        .TW_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .scale_en  (scale_en),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference for out_valid: one cycle after each accepted sample once D samples are in
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            accCount = 0;
            expValid = 1'b0;
        end else if (in_valid) begin
            expValid = (accCount >= 4);
            accCount++;
        end else begin
            expValid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (out_valid !== expValid)
            validErrors++;
        if (out_valid === 1'b1) begin
            gotRe.push_back(out_re);
            gotIm.push_back(out_im);
        end
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        assertCount++;
        if (obs !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        gotRe.delete();
        gotIm.delete();
    endtask

    task automatic applyStimulus(input bit gaps);
        for (int i = 0; i < 12; i++) begin
            if (gaps && ($urandom_range(1, 0) == 1)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_re = 16'(xr[i]);
            in_im = 16'(xi[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkFrame(input string name);
        checkOutput({name, "_count"}, gotRe.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < gotRe.size()) begin
                checkOutput($sformatf("%s_re%0d", name, i), gotRe[i], er[i]);
                checkOutput($sformatf("%s_im%0d", name, i), gotIm[i], ei[i]);
            end
        end
    endtask

    task automatic clearVectors();
        for (int i = 0; i < 12; i++) begin
            xr[i] = 0;
            xi[i] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            er[i] = 0;
            ei[i] = 0;
        end
    endtask

    initial begin
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_re", out_re, 0);
        checkOutput("rst_out_im", out_im, 0);
        checkOutput("rst_ovf", ovf, 0);
        doReset();

        // Impulse at x[0]
        clearVectors();
        xr[0] = 1000;
        er[0] = 1000;
        er[4] = 1000;
        applyStimulus(1'b0);
        checkFrame("impulse");

        // Constant real input
        doReset();
        clearVectors();
        for (int i = 0; i < 8; i++) xr[i] = 1000;
        for (int i = 0; i < 4; i++) er[i] = 2000;
        applyStimulus(1'b0);
        checkFrame("const");
        checkOutput("const_ovf", ovf, 0);

        // Impulse at x[1]: twiddle W^1 on the difference
        doReset();
        clearVectors();
        xr[1] = 1000;
        er[1] = 1000;
        er[5] = 707;
        ei[5] = -707;
        applyStimulus(1'b0);
        checkFrame("tw1");

        // Saturation without scaling, then clear the sticky flag
        doReset();
        clearVectors();
        xr[0] = 30000;
        xr[4] = 30000;
        er[0] = 32767;
        applyStimulus(1'b0);
        checkFrame("sat");
        checkOutput("sat_ovf", ovf, 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", ovf, 0);

        // Same frame with scaling enabled
        doReset();
        scale_en = 1'b1;
        er[0] = 30000;
        applyStimulus(1'b0);
        scale_en = 1'b0;
        checkFrame("scaled");
        checkOutput("scaled_ovf", ovf, 0);

        // Impulse frame with random valid gaps
        doReset();
        clearVectors();
        xr[0] = 1000;
        er[0] = 1000;
        er[4] = 1000;
        applyStimulus(1'b1);
        checkFrame("gaps");

        // Reset after five accepted samples, then a full frame
        doReset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re = 16'(xr[i]);
            in_im = '0;
        end
        doReset();
        applyStimulus(1'b0);
        checkFrame("midreset");

        checkOutput("valid_timing", validErrors, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
